// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX deserializer and its checkers.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } deser_state_t;

  localparam int unsigned SAMPLE_OFFSET  = 2;
  localparam int unsigned DATA_WIDTH_MAX = 16;
  localparam logic        PARITY_EVEN    = 1'b0;
  localparam logic        PARITY_ODD     = 1'b1;

endpackage

// File: rtl/uart_rx_sample_strobe.sv
// Mid-bit sample strobe: fires when edge_count reaches Prescale/2 + SAMPLE_OFFSET.
module uart_rx_sample_strobe
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned EDGE_W  = 5
) (
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [EDGE_W-1:0]  edge_count,
  output logic               strobe
);

  // Compare wide enough that neither Prescale/2+offset nor edge_count is truncated.
  localparam int unsigned CMP_W = (EDGE_W > PRESC_W + 1) ? EDGE_W : PRESC_W + 1;

  logic [CMP_W-1:0] target;
  logic [CMP_W-1:0] edge_ext;

  assign target   = CMP_W'({1'b0, prescale} >> 1) + CMP_W'(SAMPLE_OFFSET);
  assign edge_ext = CMP_W'(edge_count);
  assign strobe   = enable && (edge_ext == target);

endmodule

// File: rtl/uart_rx_deser_param.sv
// Parametrised UART RX deserializer with run-time length, bit order and done pulse.
// Optional parity calculation enabled by macro UART_RX_DESER_PARITY_EN.
module uart_rx_deser_param
  import uart_rx_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned PRESC_W    = 6,
  parameter  int unsigned EDGE_W     = 5,
  localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sampled_bit,
  input  logic                  deser_en,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic [EDGE_W-1:0]     edge_count,
  input  logic [CNT_W-1:0]      data_len,
  input  logic                  msb_first,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  deser_done,
  output logic [CNT_W-1:0]      bit_cnt
`ifdef UART_RX_DESER_PARITY_EN
  ,
  input  logic                  par_type,
  output logic                  par_calc
`endif
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DATA_WIDTH);

  deser_state_t          state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt, pdata_nxt;
  logic [CNT_W-1:0]      cnt_nxt, eff_len, eff_len_nxt, len_sel;
  logic                  order_msb, order_nxt, done_nxt, strobe;
`ifdef UART_RX_DESER_PARITY_EN
  logic                  par_odd, par_odd_nxt, par_nxt;
`endif

  uart_rx_sample_strobe #(
    .PRESC_W (PRESC_W),
    .EDGE_W  (EDGE_W)
  ) u_strobe (
    .enable     (deser_en),
    .prescale   (Prescale),
    .edge_count (edge_count),
    .strobe     (strobe)
  );

  assign len_sel = ((data_len == '0) || (data_len > MAX_LEN)) ? MAX_LEN : data_len;

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    cnt_nxt     = bit_cnt;
    eff_len_nxt = eff_len;
    order_nxt   = order_msb;
    pdata_nxt   = P_DATA;
    done_nxt    = 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
    par_odd_nxt = par_odd;
    par_nxt     = par_calc;
`endif
    case (state)
      IDLE: begin
        if (deser_en) begin
          eff_len_nxt = len_sel;
          order_nxt   = msb_first;
          shift_nxt   = '0;
          cnt_nxt     = '0;
`ifdef UART_RX_DESER_PARITY_EN
          par_odd_nxt = par_type;
`endif
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // strobe already requires deser_en, so an abort never captures a bit
        if (!deser_en) begin
          shift_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (strobe) begin
          if (order_msb) begin
            shift_nxt = {shift_reg[DATA_WIDTH-2:0], sampled_bit};
          end else begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
              if (bit_cnt == CNT_W'(i)) shift_nxt[i] = sampled_bit;
            end
          end
          cnt_nxt = bit_cnt + CNT_W'(1);
          if (cnt_nxt == eff_len) begin
            pdata_nxt = shift_nxt;
            done_nxt  = 1'b1;
`ifdef UART_RX_DESER_PARITY_EN
            // bits above eff_len are zero, so full-width XOR equals the eff_len slice
            par_nxt   = (^shift_nxt) ^ par_odd;
`endif
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!deser_en) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      eff_len    <= MAX_LEN;
      order_msb  <= 1'b0;
      P_DATA     <= '0;
      deser_done <= 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
      par_odd    <= PARITY_EVEN;
      par_calc   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= cnt_nxt;
      eff_len    <= eff_len_nxt;
      order_msb  <= order_nxt;
      P_DATA     <= pdata_nxt;
      deser_done <= done_nxt;
`ifdef UART_RX_DESER_PARITY_EN
      par_odd    <= par_odd_nxt;
      par_calc   <= par_nxt;
`endif
    end
  end

endmodule
